mem_bw_regulator: RTL and testbench

- Per-DSID token-bucket scheduler on the core-to-memory AXI path, between the pardcore memory master and the address mapper.
- Gates AR/AW address handshakes so each DSID (carried in a*user) gets a configured share of the memory port's transaction rate.
- Only AR/AW valid/ready are controlled. W/R/B and address payloads pass through outside this block.
- Control software programs it through a simple register-write port.

---
 rtl/mem_bw_pkg.sv | 23 ++
 rtl/mem_bw_regulator_bucket.sv | 46 ++++
 rtl/mem_bw_regulator.sv | 126 ++++++++++++
 tb/tb_mem_bw_regulator.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bw_pkg.sv
// Shared constants and types for the per-DSID memory bandwidth regulator.
package mem_bw_pkg;

  localparam int DSID_W   = 16;
  localparam int N_DSID   = 4;
  localparam int IDX_W    = 2;
  localparam int TOKEN_W  = 16;
  localparam int PERIOD_W = 16;

  localparam logic [TOKEN_W-1:0] RESET_MAX = 16'hFFFF;
  localparam logic [TOKEN_W-1:0] RESET_INC = 16'h0100;

  localparam logic [1:0] CFG_EN     = 2'd0;
  localparam logic [1:0] CFG_PERIOD = 2'd1;
  localparam logic [1:0] CFG_INC    = 2'd2;
  localparam logic [1:0] CFG_MAX    = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } grant_state_e;

endpackage

// File: rtl/mem_bw_regulator_bucket.sv
// One token bucket: debit, periodic refill and saturation at a programmable max.
module token_bucket
  import mem_bw_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               refill_i,
  input  logic [1:0]         debit_i,
  input  logic               inc_we_i,
  input  logic               max_we_i,
  input  logic [TOKEN_W-1:0] wdata_i,
  output logic [TOKEN_W-1:0] tokens_o
);

  logic [TOKEN_W-1:0] tokens_q, tokens_d;
  logic [TOKEN_W-1:0] inc_q, inc_d;
  logic [TOKEN_W-1:0] max_q, max_d;
  logic [TOKEN_W:0]   sum;

  // One extra bit keeps the refill from wrapping before saturation; the old
  // max is used here, so a lowered max clamps on the following update.
  always_comb begin
    sum = {1'b0, tokens_q} - {{(TOKEN_W-1){1'b0}}, debit_i};
    if (refill_i) begin
      sum = sum + {1'b0, inc_q};
    end
    tokens_d = (sum > {1'b0, max_q}) ? max_q : sum[TOKEN_W-1:0];
    inc_d    = inc_we_i ? wdata_i : inc_q;
    max_d    = max_we_i ? wdata_i : max_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tokens_q <= RESET_MAX;
      inc_q    <= RESET_INC;
      max_q    <= RESET_MAX;
    end else begin
      tokens_q <= tokens_d;
      inc_q    <= inc_d;
      max_q    <= max_d;
    end
  end

  assign tokens_o = tokens_q;

endmodule

// File: rtl/mem_bw_regulator.sv
// Per-DSID token-bucket gate on the AR/AW address handshakes of the memory port.
module mem_bw_regulator
  import mem_bw_pkg::*;
(
  input  logic                        uncoreclk,
  input  logic                        uncorerstn,
  input  logic                        s_arvalid,
  output logic                        s_arready,
  input  logic [DSID_W-1:0]           s_aruser,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  input  logic                        s_awvalid,
  output logic                        s_awready,
  input  logic [DSID_W-1:0]           s_awuser,
  output logic                        m_awvalid,
  input  logic                        m_awready,
  input  logic                        cfg_wen,
  input  logic [1:0]                  cfg_sel,
  input  logic [DSID_W-1:0]           cfg_idx,
  input  logic [TOKEN_W-1:0]          cfg_wdata,
  output logic [N_DSID*TOKEN_W-1:0]   tokens_flat,
  output logic [N_DSID-1:0]           throttled
);

  logic                en_q, en_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  grant_state_e        arState_q, arState_d, awState_q, awState_d;
  logic                ptr_q, ptr_d;
  logic [N_DSID-1:0]   throttled_q, throttled_d;

  logic [TOKEN_W-1:0]  tokens [N_DSID];
  logic [1:0]          debit [N_DSID];
  logic [N_DSID-1:0]   incWe, maxWe;
  logic                refill, cfgIdxOk;
  logic                arReq, awReq, arInRange, awInRange, arGrant, awGrant, contend;
  logic [IDX_W-1:0]    arIdx, awIdx;
  logic                arPass, awPass;

  // Configuration decode, refill timing and per-lane debit accounting.
  always_comb begin
    cfgIdxOk  = cfg_idx < DSID_W'(N_DSID);
    refill    = cnt_q >= period_q;
    en_d      = (cfg_wen && cfg_sel == CFG_EN) ? cfg_wdata[0] : en_q;
    period_d  = (cfg_wen && cfg_sel == CFG_PERIOD) ? cfg_wdata[PERIOD_W-1:0] : period_q;
    cnt_d     = (cfg_wen && cfg_sel == CFG_PERIOD) || refill ? '0 : cnt_q + 1'b1;
    arInRange = s_aruser < DSID_W'(N_DSID);
    awInRange = s_awuser < DSID_W'(N_DSID);
    arIdx     = s_aruser[IDX_W-1:0];
    awIdx     = s_awuser[IDX_W-1:0];
    arReq     = en_q && arState_q == IDLE && s_arvalid;
    awReq     = en_q && awState_q == IDLE && s_awvalid;
    contend   = arReq && awReq && arInRange && awInRange && arIdx == awIdx &&
                tokens[arIdx] == TOKEN_W'(1);
    arGrant   = arReq && (!arInRange || (tokens[arIdx] != '0 && !(contend && ptr_q)));
    awGrant   = awReq && (!awInRange || (tokens[awIdx] != '0 && !(contend && !ptr_q)));
    ptr_d     = contend ? ~ptr_q : ptr_q;
    for (int i = 0; i < N_DSID; i++) begin
      incWe[i] = cfg_wen && cfg_sel == CFG_INC && cfgIdxOk && cfg_idx[IDX_W-1:0] == IDX_W'(i);
      maxWe[i] = cfg_wen && cfg_sel == CFG_MAX && cfgIdxOk && cfg_idx[IDX_W-1:0] == IDX_W'(i);
      debit[i] = {1'b0, arGrant && arInRange && arIdx == IDX_W'(i)} +
                 {1'b0, awGrant && awInRange && awIdx == IDX_W'(i)};
      throttled_d[i] = ((arReq && arInRange && arIdx == IDX_W'(i)) ||
                        (awReq && awInRange && awIdx == IDX_W'(i))) && tokens[i] == '0;
    end
  end

  // Grant FSMs: a granted channel stays open until its handshake, whatever en does.
  always_comb begin
    arState_d = arState_q;
    awState_d = awState_q;
    arPass    = arState_q == GRANT || !en_q;
    awPass    = awState_q == GRANT || !en_q;
    m_arvalid = uncorerstn && arPass && s_arvalid;
    s_arready = uncorerstn && arPass && m_arready;
    m_awvalid = uncorerstn && awPass && s_awvalid;
    s_awready = uncorerstn && awPass && m_awready;
    case (arState_q)
      IDLE:    if (arGrant) arState_d = GRANT;
      GRANT:   if (s_arvalid && m_arready) arState_d = IDLE;
      default: arState_d = IDLE;
    endcase
    case (awState_q)
      IDLE:    if (awGrant) awState_d = GRANT;
      GRANT:   if (s_awvalid && m_awready) awState_d = IDLE;
      default: awState_d = IDLE;
    endcase
  end

  always_ff @(posedge uncoreclk or negedge uncorerstn) begin
    if (!uncorerstn) begin
      en_q        <= 1'b0;
      period_q    <= '0;
      cnt_q       <= '0;
      arState_q   <= IDLE;
      awState_q   <= IDLE;
      ptr_q       <= 1'b0;
      throttled_q <= '0;
    end else begin
      en_q        <= en_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
      arState_q   <= arState_d;
      awState_q   <= awState_d;
      ptr_q       <= ptr_d;
      throttled_q <= throttled_d;
    end
  end

  for (genvar i = 0; i < N_DSID; i++) begin : gBucket
    token_bucket uBucket (
      .clk      (uncoreclk),
      .rst_n    (uncorerstn),
      .refill_i (refill),
      .debit_i  (debit[i]),
      .inc_we_i (incWe[i]),
      .max_we_i (maxWe[i]),
      .wdata_i  (cfg_wdata),
      .tokens_o (tokens[i])
    );
    assign tokens_flat[i*TOKEN_W +: TOKEN_W] = tokens[i];
  end

  assign throttled = throttled_q;

endmodule

// File: tb/tb_mem_bw_regulator.sv
// Self-checking bench: bypass vector table, directed corner sequences and a random run against a cycle model.
module tb_mem_bw_regulator;
  import mem_bw_pkg::*;

  logic                      uncoreclk = 1'b0;
  logic                      uncorerstn;
  logic                      s_arvalid, s_arready, m_arvalid, m_arready;
  logic                      s_awvalid, s_awready, m_awvalid, m_awready;
  logic [DSID_W-1:0]         s_aruser, s_awuser;
  logic                      cfg_wen;
  logic [1:0]                cfg_sel;
  logic [DSID_W-1:0]         cfg_idx;
  logic [TOKEN_W-1:0]        cfg_wdata;
  logic [N_DSID*TOKEN_W-1:0] tokens_flat;
  logic [N_DSID-1:0]         throttled;

  mem_bw_regulator dut (
    .uncoreclk(uncoreclk), .uncorerstn(uncorerstn),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_aruser(s_aruser),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awuser(s_awuser),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .cfg_wen(cfg_wen), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata),
    .tokens_flat(tokens_flat), .throttled(throttled)
  );

  always #5 uncoreclk = ~uncoreclk;

  typedef struct {
    bit sAv, mAr, sWv, mAw;
    bit eMav, eSar, eMwv, eSwr;
  } vec_t;

  int testsRun, testsFailed;
  int arLeft, awLeft, arHs, awHs, cyc, cycP;
  bit autoDrive, randMode;

  int mTok[N_DSID], mInc[N_DSID], mMax[N_DSID];
  int mPeriod, mCnt;
  bit mEn, mPtr;
  bit mBusy[2];
  bit [N_DSID-1:0] mThr;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic modelReset();
    mEn = 0; mPeriod = 0; mCnt = 0; mPtr = 0; mThr = '0;
    mBusy[0] = 0; mBusy[1] = 0;
    for (int i = 0; i < N_DSID; i++) begin
      mTok[i] = 'hFFFF; mInc[i] = 'h100; mMax[i] = 'hFFFF;
    end
  endtask

  // Reference: per-DSID demand is compared against the bucket, ties broken by the pointer.
  task automatic modelAdvance();
    bit want[2], grant[2], sv[2], rdy[2];
    int dsid[2], debit[N_DSID], dem, t;
    bit refill;
    bit [N_DSID-1:0] nThr;
    sv[0] = s_arvalid; sv[1] = s_awvalid; rdy[0] = m_arready; rdy[1] = m_awready;
    dsid[0] = int'(s_aruser); dsid[1] = int'(s_awuser);
    for (int c = 0; c < 2; c++) begin
      want[c]  = mEn && !mBusy[c] && sv[c];
      grant[c] = want[c] && dsid[c] >= N_DSID;
    end
    nThr = '0;
    for (int d = 0; d < N_DSID; d++) begin
      dem = 0; debit[d] = 0;
      for (int c = 0; c < 2; c++) if (want[c] && dsid[c] == d) dem++;
      if (dem > 0 && mTok[d] >= dem) begin
        for (int c = 0; c < 2; c++) if (want[c] && dsid[c] == d) grant[c] = 1;
        debit[d] = dem;
      end else if (dem == 2 && mTok[d] == 1) begin
        grant[mPtr ? 1 : 0] = 1;
        mPtr = !mPtr;
        debit[d] = 1;
      end
      nThr[d] = mEn && dem > 0 && mTok[d] == 0;
    end
    for (int c = 0; c < 2; c++)
      mBusy[c] = mBusy[c] ? !(sv[c] && rdy[c]) : grant[c];
    refill = mCnt >= mPeriod;
    for (int d = 0; d < N_DSID; d++) begin
      t = mTok[d] - debit[d] + (refill ? mInc[d] : 0);
      mTok[d] = (t > mMax[d]) ? mMax[d] : t;
    end
    mCnt = (cfg_wen && cfg_sel == CFG_PERIOD) || refill ? 0 : mCnt + 1;
    mThr = nThr;
    if (cfg_wen) begin
      case (cfg_sel)
        CFG_EN:     mEn = cfg_wdata[0];
        CFG_PERIOD: mPeriod = int'(cfg_wdata);
        CFG_INC:    if (cfg_idx < N_DSID) mInc[cfg_idx] = int'(cfg_wdata);
        default:    if (cfg_idx < N_DSID) mMax[cfg_idx] = int'(cfg_wdata);
      endcase
    end
  endtask

  task automatic checkOutput();
    bit arOpen, awOpen;
    logic [63:0] expTok;
    arOpen = mBusy[0] || !mEn;
    awOpen = mBusy[1] || !mEn;
    expTok = '0;
    for (int i = 0; i < N_DSID; i++) expTok[i*16 +: 16] = 16'(mTok[i]);
    check("m_arvalid", m_arvalid, arOpen && s_arvalid);
    check("s_arready", s_arready, arOpen && m_arready);
    check("m_awvalid", m_awvalid, awOpen && s_awvalid);
    check("s_awready", s_awready, awOpen && m_awready);
    check("tokens_flat", tokens_flat, expTok);
    check("throttled", throttled, mThr);
  endtask

  task automatic applyStimulus();
    if (randMode) begin
      m_arready = 1'($urandom_range(0, 1));
      m_awready = 1'($urandom_range(0, 1));
      if (arLeft == 0 && $urandom_range(0, 2) == 0) begin
        arLeft = 1; s_aruser = DSID_W'($urandom_range(0, 5));
      end
      if (awLeft == 0 && $urandom_range(0, 2) == 0) begin
        awLeft = 1; s_awuser = DSID_W'($urandom_range(0, 5));
      end
      cfg_wen = ($urandom_range(0, 9) == 0);
      cfg_sel = 2'($urandom_range(0, 3));
      cfg_idx = DSID_W'($urandom_range(0, 4));
      case (cfg_sel)
        CFG_EN:     cfg_wdata = TOKEN_W'($urandom_range(0, 3) != 0);
        CFG_PERIOD: cfg_wdata = TOKEN_W'($urandom_range(0, 6));
        CFG_INC:    cfg_wdata = TOKEN_W'($urandom_range(0, 3));
        default:    cfg_wdata = TOKEN_W'($urandom_range(0, 5));
      endcase
    end
    if (autoDrive) begin
      s_arvalid = arLeft > 0;
      s_awvalid = awLeft > 0;
    end
  endtask

  task automatic step();
    bit arFire, awFire;
    @(negedge uncoreclk);
    applyStimulus();
    #1;
    checkOutput();
    arFire = s_arvalid && s_arready;
    awFire = s_awvalid && s_awready;
    modelAdvance();
    if (arFire) begin arHs++; if (arLeft > 0) arLeft--; end
    if (awFire) begin awHs++; if (awLeft > 0) awLeft--; end
    cyc++;
    @(posedge uncoreclk);
    #1;
  endtask

  task automatic cfgWrite(logic [1:0] sel, int idx, int data);
    cfg_wen = 1; cfg_sel = sel; cfg_idx = DSID_W'(idx); cfg_wdata = TOKEN_W'(data);
    step();
    cfg_wen = 0;
  endtask

  task automatic doReset();
    uncorerstn = 0;
    s_arvalid = 0; s_awvalid = 0; m_arready = 0; m_awready = 0;
    s_aruser = '0; s_awuser = '0;
    cfg_wen = 0; cfg_sel = '0; cfg_idx = '0; cfg_wdata = '0;
    arLeft = 0; awLeft = 0; arHs = 0; awHs = 0;
    autoDrive = 1; randMode = 0;
    modelReset();
    #12;
    @(negedge uncoreclk);
    uncorerstn = 1;
    @(posedge uncoreclk);
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    testsRun = 0; testsFailed = 0; cyc = 0;
    vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 1, 0, 0, 1, 1, 0, 0};
    vecs[2] = '{1, 0, 0, 0, 1, 0, 0, 0};
    vecs[3] = '{0, 1, 0, 0, 0, 1, 0, 0};
    vecs[4] = '{0, 0, 1, 1, 0, 0, 1, 1};
    vecs[5] = '{0, 0, 1, 0, 0, 0, 1, 0};
    vecs[6] = '{1, 1, 1, 1, 1, 1, 1, 1};
    vecs[7] = '{1, 0, 0, 1, 1, 0, 0, 1};

    // Reset state and bypass table.
    doReset();
    check("reset_tokens", tokens_flat, {4{16'hFFFF}});
    check("reset_throttled", throttled, 4'h0);
    autoDrive = 0;
    for (int i = 0; i < 8; i++) begin
      s_arvalid = vecs[i].sAv; m_arready = vecs[i].mAr;
      s_awvalid = vecs[i].sWv; m_awready = vecs[i].mAw;
      step();
      check($sformatf("bypass%0d_m_arvalid", i), m_arvalid, vecs[i].eMav);
      check($sformatf("bypass%0d_s_arready", i), s_arready, vecs[i].eSar);
      check($sformatf("bypass%0d_m_awvalid", i), m_awvalid, vecs[i].eMwv);
      check($sformatf("bypass%0d_s_awready", i), s_awready, vecs[i].eSwr);
    end
    check("bypass_tok0", tokens_flat[15:0], 16'hFFFF);

    // Same-DSID contention on a single token.
    doReset();
    cfgWrite(CFG_MAX, 2, 1);
    cfgWrite(CFG_INC, 2, 1);
    cfgWrite(CFG_PERIOD, 0, 29);
    cycP = cyc;
    cfgWrite(CFG_EN, 0, 1);
    m_arready = 1; m_awready = 1;
    s_aruser = 2; s_awuser = 2; arLeft = 1; awLeft = 1;
    for (int i = 0; i < 6; i++) step();
    check("contend_ar_first", arHs, 1);
    check("contend_aw_waits", awHs, 0);
    check("contend_tok2", tokens_flat[47:32], 16'h0);
    arLeft = 1;
    while (cyc - cycP < 40) step();
    check("contend_aw_second", awHs, 1);
    check("contend_ar_held", arHs, 1);
    while (cyc - cycP < 75) step();
    check("contend_ar_third", arHs, 2);

    // Throttling with a slow refill.
    doReset();
    cfgWrite(CFG_MAX, 1, 4);
    cfgWrite(CFG_INC, 1, 2);
    cfgWrite(CFG_PERIOD, 0, 99);
    cycP = cyc;
    cfgWrite(CFG_EN, 0, 1);
    m_arready = 1; s_aruser = 1; arLeft = 10;
    while (cyc - cycP < 20) step();
    check("throttle_first4", arHs, 4);
    check("throttle_flag", throttled[1], 1'b1);
    while (cyc - cycP < 150) step();
    check("throttle_after_refill1", arHs, 6);
    while (cyc - cycP < 250) step();
    check("throttle_after_refill2", arHs, 8);
    while (cyc - cycP < 350) step();
    check("throttle_after_refill3", arHs, 10);

    // Valid held through config changes while granted.
    doReset();
    cfgWrite(CFG_INC, 0, 0);
    cfgWrite(CFG_EN, 0, 1);
    s_aruser = 0; arLeft = 1; m_arready = 0;
    step(); step();
    check("held_one_debit", tokens_flat[15:0], 16'hFFFE);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) cfgWrite(CFG_MAX, 0, 0);
      else if (i == 10) cfgWrite(CFG_EN, 0, 0);
      else step();
    end
    check("held_m_arvalid", m_arvalid, 1'b1);
    check("held_no_hs", arHs, 0);
    m_arready = 1;
    step();
    check("held_hs", arHs, 1);
    step();
    check("held_clamped", tokens_flat[15:0], 16'h0);

    // Saturation and clamp to a lowered max.
    doReset();
    cfgWrite(CFG_INC, 0, 'hFFFF);
    step(); step();
    check("sat_pinned", tokens_flat[15:0], 16'hFFFF);
    cfgWrite(CFG_MAX, 0, 3);
    step();
    check("sat_clamp", tokens_flat[15:0], 16'h3);
    check("sat_other", tokens_flat[31:16], 16'hFFFF);

    // Out-of-range DSIDs pass without debit.
    doReset();
    cfgWrite(CFG_EN, 0, 1);
    m_arready = 1; m_awready = 1;
    s_aruser = DSID_W'(N_DSID); s_awuser = 7; arLeft = 1; awLeft = 1;
    for (int i = 0; i < 6; i++) step();
    check("oor_ar_hs", arHs, 1);
    check("oor_aw_hs", awHs, 1);
    check("oor_tokens", tokens_flat, {4{16'hFFFF}});

    // Asynchronous reset in the middle of a grant.
    doReset();
    cfgWrite(CFG_EN, 0, 1);
    s_aruser = 0; arLeft = 1; m_arready = 0;
    step(); step(); step();
    #3;
    uncorerstn = 0;
    #1;
    check("rst_m_arvalid", m_arvalid, 1'b0);
    check("rst_s_arready", s_arready, 1'b0);
    check("rst_tokens", tokens_flat, {4{16'hFFFF}});
    modelReset();
    arLeft = 0;
    @(negedge uncoreclk);
    uncorerstn = 1;
    @(posedge uncoreclk);
    #1;
    autoDrive = 0; s_arvalid = 1; m_arready = 1;
    step();
    check("rst_bypass_after", m_arvalid, 1'b1);
    s_arvalid = 0;

    // Random traffic and configuration against the model.
    doReset();
    randMode = 1;
    for (int i = 0; i < 3000; i++) step();
    randMode = 0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
